// File: rtl/imager_bayer_tag.sv
// ---------------------------------------------------------------------------
// imager_bayer_tag
//
// Purpose:
//   Stream stage that sits directly after the imager receiver. Untyped PIXEL
//   beats are retagged as RED / GREEN1 / GREEN2 / BLUE from the row/column
//   parity and a Bayer phase that is latched at FRAME_START. All other data
//   types pass through untouched. The output is a one-cycle registered copy of
//   the input stream.
//
// Optional build macro:
//   IMAGER_BAYER_TAG_STATS_EN  - when defined, frame dimension statistics
//                                (num_rows / num_cols / width_err /
//                                stats_valid) are generated. When undefined
//                                those outputs are constant 0.
//
// Ports:
//   clki         pixel clock, rising edge
//   resetb       asynchronous active-low reset
//   bayer_en     1 = retag pixels (sampled at FRAME_START)
//   bayer_phase  colour at row 0 / col 0: 0=R 1=Gr 2=Gb 3=B (sampled at FRAME_START)
//   dvi          input beat valid
//   dtypei       input data type
//   datai        input data
//   dvo          output beat valid (dvi delayed one cycle)
//   dtypeo       output data type
//   datao        output data
//   num_rows     rows in the last frame               (stats build)
//   num_cols     width of last counted row            (stats build)
//   width_err    row widths differed in last frame    (stats build)
//   stats_valid  one-cycle pulse when stats update    (stats build)
// ---------------------------------------------------------------------------
module imager_bayer_tag #(
   parameter int PIXEL_WIDTH = 12,
   parameter int DIM_WIDTH   = 16
) (
   input  logic                   clki,
   input  logic                   resetb,
   input  logic                   bayer_en,
   input  logic [1:0]             bayer_phase,
   input  logic                   dvi,
   input  logic [4:0]             dtypei,
   input  logic [PIXEL_WIDTH-1:0] datai,
   output logic                   dvo,
   output logic [4:0]             dtypeo,
   output logic [PIXEL_WIDTH-1:0] datao,
   output logic [DIM_WIDTH-1:0]   num_rows,
   output logic [DIM_WIDTH-1:0]   num_cols,
   output logic                   width_err,
   output logic                   stats_valid
);

   localparam logic [4:0] DTYPE_FRAME_START  = 5'd0;
   localparam logic [4:0] DTYPE_FRAME_END    = 5'd1;
   localparam logic [4:0] DTYPE_ROW_START    = 5'd2;
   localparam logic [4:0] DTYPE_ROW_END      = 5'd3;
   localparam logic [4:0] DTYPE_PIXEL        = 5'd9;
   localparam logic [4:0] DTYPE_PIXEL_RED    = 5'd10;
   localparam logic [4:0] DTYPE_PIXEL_BLUE   = 5'd11;
   localparam logic [4:0] DTYPE_PIXEL_GREEN1 = 5'd12;
   localparam logic [4:0] DTYPE_PIXEL_GREEN2 = 5'd13;

   localparam logic [DIM_WIDTH-1:0] DIM_ONE = {{(DIM_WIDTH-1){1'b0}}, 1'b1};

   // Counters stick at all-ones instead of wrapping so a runaway frame never
   // aliases back onto row/column 0 parity.
   function automatic logic [DIM_WIDTH-1:0] sat_inc(input logic [DIM_WIDTH-1:0] v);
      return (&v) ? v : v + DIM_ONE;
   endfunction

   // ------------------------------------------------------------------------
   // Tagging path
   // ------------------------------------------------------------------------
   logic                   dvo_q,     dvo_d;
   logic [4:0]             dtypeo_q,  dtypeo_d;
   logic [PIXEL_WIDTH-1:0] datao_q,   datao_d;
   logic [DIM_WIDTH-1:0]   row_idx_q, row_idx_d;
   logic [DIM_WIDTH-1:0]   col_idx_q, col_idx_d;
   logic                   en_q,      en_d;
   logic [1:0]             phase_q,   phase_d;
   logic [1:0]             colour_idx;

   // Phase is folded into the parity bits: idx 0=R, 1=Gr, 2=Gb, 3=B.
   assign colour_idx = {row_idx_q[0] ^ phase_q[1], col_idx_q[0] ^ phase_q[0]};

   always_comb begin
      dvo_d     = dvi;
      dtypeo_d  = dtypeo_q;
      datao_d   = datao_q;
      row_idx_d = row_idx_q;
      col_idx_d = col_idx_q;
      en_d      = en_q;
      phase_d   = phase_q;

      if (dvi) begin
         datao_d  = datai;
         dtypeo_d = dtypei;
         unique case (dtypei)
            DTYPE_FRAME_START: begin
               row_idx_d = '0;
               col_idx_d = '0;
               en_d      = bayer_en;
               phase_d   = bayer_phase;
            end
            DTYPE_ROW_START: begin
               col_idx_d = '0;
            end
            DTYPE_ROW_END: begin
               row_idx_d = sat_inc(row_idx_q);
               col_idx_d = '0;
            end
            DTYPE_PIXEL: begin
               col_idx_d = sat_inc(col_idx_q);
               if (en_q) begin
                  unique case (colour_idx)
                     2'd0:    dtypeo_d = DTYPE_PIXEL_RED;
                     2'd1:    dtypeo_d = DTYPE_PIXEL_GREEN1;
                     2'd2:    dtypeo_d = DTYPE_PIXEL_GREEN2;
                     default: dtypeo_d = DTYPE_PIXEL_BLUE;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clki or negedge resetb) begin
      if (!resetb) begin
         dvo_q     <= 1'b0;
         dtypeo_q  <= '0;
         datao_q   <= '0;
         row_idx_q <= '0;
         col_idx_q <= '0;
         en_q      <= 1'b0;
         phase_q   <= 2'd0;
      end else begin
         dvo_q     <= dvo_d;
         dtypeo_q  <= dtypeo_d;
         datao_q   <= datao_d;
         row_idx_q <= row_idx_d;
         col_idx_q <= col_idx_d;
         en_q      <= en_d;
         phase_q   <= phase_d;
      end
   end

   assign dvo    = dvo_q;
   assign dtypeo = dtypeo_q;
   assign datao  = datao_q;

   // ------------------------------------------------------------------------
   // Frame statistics
   // ------------------------------------------------------------------------
`ifdef IMAGER_BAYER_TAG_STATS_EN
   logic [DIM_WIDTH-1:0] rows_cnt_q,    rows_cnt_d;
   logic [DIM_WIDTH-1:0] ref_width_q,   ref_width_d;
   logic                 have_ref_q,    have_ref_d;
   logic                 err_flag_q,    err_flag_d;
   logic [DIM_WIDTH-1:0] last_width_q,  last_width_d;
   logic [DIM_WIDTH-1:0] num_rows_q,    num_rows_d;
   logic [DIM_WIDTH-1:0] num_cols_q,    num_cols_d;
   logic                 width_err_q,   width_err_d;
   logic                 stats_valid_q, stats_valid_d;
   logic                 count_row;

   // A FRAME_END with pixels pending closes a final row that had no ROW_END.
   assign count_row = dvi && ((dtypei == DTYPE_ROW_END) ||
                              ((dtypei == DTYPE_FRAME_END) && (col_idx_q != '0)));

   always_comb begin
      rows_cnt_d    = rows_cnt_q;
      ref_width_d   = ref_width_q;
      have_ref_d    = have_ref_q;
      err_flag_d    = err_flag_q;
      last_width_d  = last_width_q;
      num_rows_d    = num_rows_q;
      num_cols_d    = num_cols_q;
      width_err_d   = width_err_q;
      stats_valid_d = 1'b0;

      if (dvi && (dtypei == DTYPE_FRAME_START)) begin
         rows_cnt_d   = '0;
         have_ref_d   = 1'b0;
         err_flag_d   = 1'b0;
         last_width_d = '0;
      end else if (count_row) begin
         rows_cnt_d   = sat_inc(rows_cnt_q);
         last_width_d = col_idx_q;
         if (!have_ref_q) begin
            ref_width_d = col_idx_q;
            have_ref_d  = 1'b1;
         end else if (col_idx_q != ref_width_q) begin
            err_flag_d = 1'b1;
         end
      end

      // Publish including the row closed by this same FRAME_END.
      if (dvi && (dtypei == DTYPE_FRAME_END)) begin
         num_rows_d    = rows_cnt_d;
         num_cols_d    = last_width_d;
         width_err_d   = err_flag_d;
         stats_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clki or negedge resetb) begin
      if (!resetb) begin
         rows_cnt_q    <= '0;
         ref_width_q   <= '0;
         have_ref_q    <= 1'b0;
         err_flag_q    <= 1'b0;
         last_width_q  <= '0;
         num_rows_q    <= '0;
         num_cols_q    <= '0;
         width_err_q   <= 1'b0;
         stats_valid_q <= 1'b0;
      end else begin
         rows_cnt_q    <= rows_cnt_d;
         ref_width_q   <= ref_width_d;
         have_ref_q    <= have_ref_d;
         err_flag_q    <= err_flag_d;
         last_width_q  <= last_width_d;
         num_rows_q    <= num_rows_d;
         num_cols_q    <= num_cols_d;
         width_err_q   <= width_err_d;
         stats_valid_q <= stats_valid_d;
      end
   end

   assign num_rows    = num_rows_q;
   assign num_cols    = num_cols_q;
   assign width_err   = width_err_q;
   assign stats_valid = stats_valid_q;
`else
   assign num_rows    = '0;
   assign num_cols    = '0;
   assign width_err   = 1'b0;
   assign stats_valid = 1'b0;
`endif

endmodule

// File: tb/tb_imager_bayer_tag.sv
// Scoreboard bench for imager_bayer_tag: the stimulus side computes the
// expected output beat from a behavioural frame model and queues it; a monitor
// on the falling edge pops and compares whenever dvo is high.
module tb_imager_bayer_tag;

   localparam int PW = 12;
   localparam int DW = 16;

   localparam logic [4:0] FS = 5'd0, FE = 5'd1, RS = 5'd2, RE = 5'd3;
   localparam logic [4:0] HDR = 5'd8, PIX = 5'd9;

   logic          clk = 1'b0;
   logic          resetb = 1'b0;
   logic          bayer_en = 1'b0;
   logic [1:0]    bayer_phase = 2'd0;
   logic          dvi = 1'b0;
   logic [4:0]    dtypei = '0;
   logic [PW-1:0] datai = '0;
   logic          dvo;
   logic [4:0]    dtypeo;
   logic [PW-1:0] datao;
   logic [DW-1:0] num_rows, num_cols;
   logic          width_err, stats_valid;

   imager_bayer_tag #(.PIXEL_WIDTH(PW), .DIM_WIDTH(DW)) dut (
      .clki(clk), .resetb(resetb), .bayer_en(bayer_en), .bayer_phase(bayer_phase),
      .dvi(dvi), .dtypei(dtypei), .datai(datai),
      .dvo(dvo), .dtypeo(dtypeo), .datao(datao),
      .num_rows(num_rows), .num_cols(num_cols), .width_err(width_err),
      .stats_valid(stats_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [4:0]    t;
      logic [PW-1:0] d;
      int            cyc;
      bit            fe;
      int            nr;
      int            nc;
      bit            err;
   } exp_t;
   exp_t exp_q[$];

   // Colour seen at (row parity, col parity) for each Bayer phase, written out
   // as the four standard mosaics RGGB, GRBG, GBRG, BGGR.
   int pat [4][4] = '{'{10, 12, 13, 11},
                      '{12, 10, 11, 13},
                      '{13, 11, 10, 12},
                      '{11, 13, 12, 10}};

   // Reference model state
   int  m_row = 0, m_col = 0, m_phase = 0;
   bit  m_en = 0;
   int  m_rows = 0, m_ref = 0, m_last = 0;
   bit  m_have_ref = 0, m_err = 0;
   bit  gaps = 0;

   function automatic void model_reset();
      m_row = 0; m_col = 0; m_phase = 0; m_en = 0;
      m_rows = 0; m_ref = 0; m_last = 0; m_have_ref = 0; m_err = 0;
   endfunction

   function automatic void count_row(input int w);
      m_rows++;
      m_last = w;
      if (!m_have_ref) begin m_ref = w; m_have_ref = 1; end
      else if (w != m_ref) m_err = 1;
   endfunction

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (resetb && dvo) begin
         if (exp_q.size() == 0) begin
            check("unexpected_dvo", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("latency", cyc, e.cyc + 1);
            check("dtypeo", int'(dtypeo), int'(e.t));
            check("datao", int'(datao), int'(e.d));
`ifdef IMAGER_BAYER_TAG_STATS_EN
            check("stats_valid", int'(stats_valid), int'(e.fe));
            if (e.fe) begin
               check("num_rows", int'(num_rows), e.nr);
               check("num_cols", int'(num_cols), e.nc);
               check("width_err", int'(width_err), int'(e.err));
            end
`else
            check("stats_tied", int'({num_rows, num_cols, width_err, stats_valid}), 0);
`endif
         end
      end
   end

   task automatic idle();
      @(posedge clk); #1;
      dvi = 1'b0;
      dtypei = 5'($urandom);
      datai = PW'($urandom);
   endtask

   task automatic beat(input logic [4:0] t);
      exp_t e;
      logic [PW-1:0] d;
      if (gaps) repeat ($urandom_range(0, 2)) idle();
      @(posedge clk); #1;
      d = PW'($urandom);
      dvi = 1'b1; dtypei = t; datai = d;
      e.t = t; e.d = d; e.cyc = cyc; e.fe = 0; e.nr = 0; e.nc = 0; e.err = 0;
      case (t)
         FS: begin
            m_row = 0; m_col = 0; m_en = bayer_en; m_phase = int'(bayer_phase);
            m_rows = 0; m_have_ref = 0; m_err = 0; m_last = 0;
         end
         RS: m_col = 0;
         RE: begin count_row(m_col); m_row++; m_col = 0; end
         PIX: begin
            if (m_en) e.t = 5'(pat[m_phase][(m_row % 2) * 2 + (m_col % 2)]);
            m_col++;
         end
         FE: begin
            if (m_col != 0) count_row(m_col);
            e.fe = 1; e.nr = m_rows; e.nc = m_last; e.err = m_err;
         end
         default: ;
      endcase
      exp_q.push_back(e);
   endtask

   // Frame of nrows rows; row widths ncols except the last row (last_w).
   task automatic frame(input int nrows, input int ncols, input int last_w,
                        input bit last_re, input bit en, input logic [1:0] ph);
      bayer_en = en; bayer_phase = ph;
      beat(FS);
      for (int r = 0; r < nrows; r++) begin
         int w;
         w = (r == nrows - 1) ? last_w : ncols;
         for (int c = 0; c < w; c++) beat(PIX);
         if (r < nrows - 1 || last_re) beat(RE);
      end
      beat(FE);
   endtask

   task automatic drain();
      int n;
      n = 0;
      idle();
      while (exp_q.size() != 0 && n < 10) begin idle(); n++; end
      check("drain_timeout", exp_q.size(), 0);
   endtask

   initial begin
      resetb = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_dvo", int'(dvo), 0);
      check("rst_dtypeo", int'(dtypeo), 0);
      check("rst_datao", int'(datao), 0);
      check("rst_stats", int'({num_rows, num_cols, width_err, stats_valid}), 0);
      resetb = 1'b1;
      model_reset();

      // Pixels before any FRAME_START stay untagged
      for (int i = 0; i < 3; i++) beat(PIX);

      // Directed frames from the plan
      frame(2, 4, 4, 1, 1, 2'd0);
      frame(2, 4, 4, 1, 1, 2'd3);
      frame(2, 4, 4, 1, 1, 2'd1);
      frame(2, 4, 4, 1, 1, 2'd2);

      // Enable raised mid-frame: this frame stays 9, the next is tagged
      bayer_en = 0; bayer_phase = 2'd0;
      beat(FS); beat(PIX); beat(PIX);
      bayer_en = 1; bayer_phase = 2'd3;
      beat(PIX); beat(RE); beat(PIX); beat(PIX); beat(FE);
      frame(2, 3, 3, 1, 1, 2'd0);

      // Gaps, headers and frame end inside the stream
      gaps = 1;
      bayer_en = 1; bayer_phase = 2'd0;
      beat(FS); beat(HDR); beat(PIX); beat(HDR); beat(PIX); beat(PIX);
      beat(RE); beat(RS); beat(PIX); beat(5'd12); beat(PIX); beat(FE);
      gaps = 0;

      // Stats frames: 3x640 with no final ROW_END, then last row short
      frame(3, 640, 640, 0, 1, 2'd1);
      frame(3, 640, 639, 0, 1, 2'd2);
      frame(2, 5, 5, 1, 1, 2'd0);

      // Randomized frames with stray types and mid-frame config changes
      for (int f = 0; f < 40; f++) begin
         int nr;
         gaps = $urandom_range(0, 1);
         bayer_en = $urandom_range(0, 1);
         bayer_phase = 2'($urandom);
         beat(FS);
         nr = $urandom_range(1, 5);
         for (int r = 0; r < nr; r++) begin
            int w;
            if ($urandom_range(0, 3) == 0) beat(RS);
            w = $urandom_range(1, 8);
            for (int c = 0; c < w; c++) begin
               case ($urandom_range(0, 9))
                  0: beat(5'($urandom_range(4, 8)));
                  1: beat(5'($urandom_range(10, 13)));
                  2: beat(5'($urandom_range(20, 31)));
                  3: begin bayer_en = $urandom_range(0, 1); bayer_phase = 2'($urandom); end
                  default: ;
               endcase
               beat(PIX);
            end
            if (r < nr - 1 || $urandom_range(0, 1) == 1) beat(RE);
         end
         beat(FE);
      end
      gaps = 0;
      drain();

      // Reset asserted mid-row
      frame(1, 2, 2, 1, 1, 2'd0);
      bayer_en = 1; bayer_phase = 2'd1;
      beat(FS); beat(PIX); beat(PIX); beat(PIX);
      drain();
      @(posedge clk); #3;
      resetb = 1'b0;
      #1;
      check("mid_rst_dvo", int'(dvo), 0);
      check("mid_rst_dtypeo", int'(dtypeo), 0);
      check("mid_rst_datao", int'(datao), 0);
      check("mid_rst_stats", int'({num_rows, num_cols, width_err, stats_valid}), 0);
      model_reset();
      @(posedge clk); #1;
      resetb = 1'b1;
      for (int i = 0; i < 4; i++) beat(PIX);
      frame(2, 2, 2, 1, 1, 2'd3);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Absolute watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
